key_pio_sequencer: RTL and testbench
====================================

# key_pio_sequencer

Avalon-MM master that owns the single-bit push-button PIO slave and converts its edge-capture register into a timestamped event stream. It configures the PIO after reset, then polls the edge-capture register on a timer or on the PIO `irq`. On each captured edge it clears the register and pushes a timestamp into an internal FIFO, which the password-checker datapath drains through a valid/ready interface.

## Interface
- `POLL_DIV`, 1000: idle cycles between polls; must be at least 1.
- `TS_W`, 24: timestamp counter and event width.
- `DEPTH`, 8: event FIFO depth; must be a power of 2 and at least 2.
- `IRQ_MASK`, 1'b0: value written to the PIO irq-mask register during init.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  polling enable; when low, the block holds in IDLE once init completes.
- `pio_irq`  in  1  PIO irq; when high in IDLE with `enable` high, forces an immediate poll.
- `m_address`  out  2  PIO register address.
- `m_chipselect`  out  1  high for every PIO access.
- `m_write_n`  out  1  active-low write strobe.
- `m_writedata`  out  32  PIO write data.
- `m_readdata`  in  32  PIO read data; only bit 0 is used.
- `evt_valid`  out  1  FIFO not empty.
- `evt_ready`  in  1  consumer pop; a pop occurs when `evt_valid` and `evt_ready` are both high.
- `evt_time`  out  TS_W  timestamp at the FIFO head.
- `evt_count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky flag: an event was dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Reset values:
  - `m_address`=0, `m_chipselect`=0, `m_write_n`=1, `m_writedata`=0.
  - `evt_valid`=0, `evt_time`=0, `evt_count`=0, `overflow`=0.
  - Timestamp counter=0, poll timer=0, state=INIT_MASK.
- PIO slave behaviour:
  - Read data is registered. Data for the address presented in cycle N is valid in cycle N+1, regardless of chipselect.
  - A write of bit0=1 to address 3 clears edge-capture. The clear takes priority over a new edge in the same cycle.
- States:
  - **INIT_MASK**: 1 cycle. Write address 2, data {31'b0, IRQ_MASK}. Go to INIT_CLR.
  - **INIT_CLR**: 1 cycle. Write address 3, data 1, to discard stale edges. Go to IDLE.
  - **IDLE**: bus inactive (`m_chipselect`=0, `m_write_n`=1).
    - With `enable` high, the poll timer increments each cycle.
    - Go to RD_ADDR when the timer reaches POLL_DIV-1, or when `pio_irq` is high. The timer resets to 0 on exit.
    - With `enable` low, the timer is held at 0.
  - **RD_ADDR**: drive address 3, chipselect 1, write_n 1. Go to RD_SAMPLE.
  - **RD_SAMPLE**: keep address 3. Sample `m_readdata[0]`.
    - If 1: latch the current timestamp, go to CLEAR.
    - If 0: go to IDLE.
  - **CLEAR**: write address 3, data 1. Push the latched timestamp into the FIFO. Go to IDLE.
- Timestamp: free-running TS_W-bit counter, incremented every cycle, wrapping modulo 2^TS_W.
- FIFO push rules:
  - A push is accepted when `evt_count`<DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the event is dropped and `overflow` is set.
- FIFO pop with an empty FIFO: no effect.
- Push and pop in the same cycle: `evt_count` is unchanged.
- `overflow` set and `ovf_clr` in the same cycle: set wins.
- `enable` deasserted mid-poll: the current RD/CLEAR sequence completes, then the block holds in IDLE.
- Reset asserted mid-operation: all state returns to reset values immediately. The FIFO is emptied. Init reruns after reset is released.

## Timing
- First bus write (INIT_MASK) occurs in the first clock edge after reset release.
- Poll with no edge: 2 bus cycles (RD_ADDR, RD_SAMPLE).
- Poll with an edge: 3 bus cycles.
- `evt_valid` rises 1 cycle after the CLEAR cycle, when the FIFO was empty.
- Poll period with `enable` held high and no edges: POLL_DIV+2 cycles.
- Edges arriving during CLEAR are lost. This is acceptable given key bounce and press intervals.
- `evt_time` and `evt_count` reflect a pop in the cycle after the pop.

## Structure
- Package `key_pio_pkg`:
  - State enum.
  - PIO address constants: DATA=0, MASK=2, EDGE=3.
- Sub-module `evt_fifo`:
  - Synchronous FIFO, parameters `W` and `DEPTH`.
  - Read head is combinational.
  - Storage is reset to 0.
  - Provides occupancy count.

## Test plan
- Reset release -> address 2 write with data 0, then address 3 write with data 1, then IDLE; all outputs at their reset values beforehand.
- POLL_DIV=4, slave edge-capture=0 -> a read of address 3 every 6 cycles; no writes; `evt_valid` stays 0.
- Edge-capture set at timestamp 100 with POLL_DIV=4 -> the next poll reads 1 and writes address 3 data 1; `evt_valid`=1, and `evt_time` equals the timestamp latched in RD_SAMPLE.
- DEPTH=2, 3 edges, `evt_ready`=0 -> `evt_count`=2, `overflow`=1; `ovf_clr` -> `overflow`=0.
- FIFO full, with a push and a pop in the same cycle -> push accepted, `evt_count` stays 2, `overflow` stays 0.
- `pio_irq` high in IDLE at timer=1 -> RD_ADDR in the next cycle. Reset asserted during CLEAR -> the FIFO empties and init reruns.

Source files
------------

// File: rtl/key_pio_pkg.sv
// Shared types for the push-button PIO sequencer: FSM states, PIO register map
// and the master-side bus request word.
package key_pio_pkg;

  typedef enum logic [2:0] {
    INIT_MASK,
    INIT_CLR,
    IDLE,
    RD_ADDR,
    RD_SAMPLE,
    CLEAR
  } state_e;

  localparam logic [1:0] PIO_DATA = 2'd0;
  localparam logic [1:0] PIO_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE = 2'd3;

  typedef struct packed {
    logic [1:0]  addr;
    logic        cs;
    logic        wr_n;
    logic [31:0] wdata;
  } pio_req_t;

  function automatic pio_req_t pio_idle();
    pio_idle = '{addr: PIO_DATA, cs: 1'b0, wr_n: 1'b1, wdata: 32'd0};
  endfunction

  function automatic pio_req_t pio_rd(input logic [1:0] a);
    pio_rd = '{addr: a, cs: 1'b1, wr_n: 1'b1, wdata: 32'd0};
  endfunction

  function automatic pio_req_t pio_wr(input logic [1:0] a, input logic [31:0] d);
    pio_wr = '{addr: a, cs: 1'b1, wr_n: 1'b0, wdata: d};
  endfunction

endpackage

// File: rtl/key_pio_sequencer_evt_fifo.sv
// Synchronous event FIFO with combinational head, occupancy count and a
// drop pulse when a push finds no room.
module evt_fifo #(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wptr_q, rptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    pop, push_ok;

  assign pop     = pop_i && (count_q != '0);
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop);
  assign drop_o  = push_i && !push_ok;
  assign rdata_o = mem_q[rptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/key_pio_sequencer.sv
// Avalon-MM master for the push-button PIO: init, timer/irq-driven polling of
// edge-capture, clear-on-hit, and a timestamped event FIFO for the consumer.
module key_pio_sequencer
  import key_pio_pkg::*;
#(
  parameter int unsigned POLL_DIV = 1000,
  parameter int unsigned TS_W     = 24,
  parameter int unsigned DEPTH    = 8,
  parameter logic        IRQ_MASK = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   pio_irq,
  output logic [1:0]             m_address,
  output logic                   m_chipselect,
  output logic                   m_write_n,
  output logic [31:0]            m_writedata,
  input  logic [31:0]            m_readdata,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [TS_W-1:0]        evt_time,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int unsigned TMR_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  state_e            state_q;
  pio_req_t          req_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [TS_W-1:0]   ts_q, ts_d, lat_q;
  logic              overflow_q, overflow_d;
  logic              push, drop;
  logic              unused_rd;

  assign unused_rd = ^m_readdata[31:1];

  assign m_address    = req_q.addr;
  assign m_chipselect = req_q.cs;
  assign m_write_n    = req_q.wr_n;
  assign m_writedata  = req_q.wdata;
  assign overflow     = overflow_q;

  assign ts_d       = ts_q + TS_W'(1);
  assign push       = (state_q == CLEAR);
  assign overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);

  // Bus request is registered on entry, so each state's access is on the bus
  // during that state; the init writes trail their state by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT_MASK;
      req_q   <= pio_idle();
      tmr_q   <= '0;
      lat_q   <= '0;
    end else begin
      case (state_q)
        INIT_MASK: begin
          req_q   <= pio_wr(PIO_MASK, {31'b0, IRQ_MASK});
          state_q <= INIT_CLR;
        end
        INIT_CLR: begin
          req_q   <= pio_wr(PIO_EDGE, 32'd1);
          tmr_q   <= '0;
          state_q <= IDLE;
        end
        IDLE: begin
          req_q <= pio_idle();
          if (!enable) begin
            tmr_q <= '0;
          end else if (pio_irq || (tmr_q == TMR_W'(POLL_DIV - 1))) begin
            tmr_q   <= '0;
            req_q   <= pio_rd(PIO_EDGE);
            state_q <= RD_ADDR;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        RD_ADDR: begin
          req_q   <= pio_rd(PIO_EDGE);
          state_q <= RD_SAMPLE;
        end
        RD_SAMPLE: begin
          if (m_readdata[0]) begin
            lat_q   <= ts_q;
            req_q   <= pio_wr(PIO_EDGE, 32'd1);
            state_q <= CLEAR;
          end else begin
            req_q   <= pio_idle();
            state_q <= IDLE;
          end
        end
        CLEAR: begin
          req_q   <= pio_idle();
          state_q <= IDLE;
        end
        default: begin
          req_q   <= pio_idle();
          state_q <= INIT_MASK;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
    end
  end

  evt_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .push_i    (push),
    .pop_i     (evt_ready),
    .wdata_i   (lat_q),
    .rdata_o   (evt_time),
    .valid_o   (evt_valid),
    .count_o   (evt_count),
    .drop_o    (drop)
  );

endmodule

// File: tb/tb_key_pio_sequencer.sv
// Directed bench for key_pio_sequencer with a PIO slave model, bus-access and
// event scoreboards keyed on a bench-side cycle counter.
module tb_key_pio_sequencer;

  localparam int unsigned POLL_DIV = 4;
  localparam int unsigned TS_W     = 24;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b1;
  logic            pio_irq = 1'b0;
  logic            evt_ready = 1'b0;
  logic            ovf_clr = 1'b0;
  logic [1:0]      m_address;
  logic            m_chipselect, m_write_n;
  logic [31:0]     m_writedata, m_readdata;
  logic            evt_valid, overflow;
  logic [TS_W-1:0] evt_time;
  logic [CW-1:0]   evt_count;

  always #5 clk = ~clk;

  key_pio_sequencer #(.POLL_DIV(POLL_DIV), .TS_W(TS_W), .DEPTH(DEPTH), .IRQ_MASK(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pio_irq(pio_irq),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_time(evt_time),
    .evt_count(evt_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  // PIO slave: registered read, write-1-to-clear edge capture beats a new edge.
  logic        edge_pulse = 1'b0;
  logic        cap_q;
  logic [31:0] rd_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      rd_q <= (m_address == 2'd3) ? {31'b0, cap_q} : 32'b0;
      if (m_chipselect && !m_write_n && m_address == 2'd3 && m_writedata[0]) cap_q <= 1'b0;
      else if (edge_pulse) cap_q <= 1'b1;
    end
  end
  assign m_readdata = rd_q;

  // Tracks the DUT timestamp by construction: both reset to 0 and count every cycle.
  int unsigned cyc;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct {
    int unsigned t;
    logic        wr;
    logic [1:0]  a;
    logic [31:0] d;
  } acc_t;

  acc_t            exp_bus[$];
  logic [TS_W-1:0] exp_evt[$];
  int              n_chk = 0;
  int              n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  always @(negedge clk) begin : bus_mon
    acc_t e;
    if (reset_n === 1'b1 && m_chipselect === 1'b1) begin
      if (exp_bus.size() == 0) begin
        chk("bus_unexpected_cs", 64'(m_chipselect), 64'd0);
      end else begin
        e = exp_bus.pop_front();
        chk("bus_time", 64'(cyc), 64'(e.t));
        chk("bus_wr_n", 64'(m_write_n), 64'(!e.wr));
        chk("bus_addr", 64'(m_address), 64'(e.a));
        if (e.wr) chk("bus_wdata", 64'(m_writedata), 64'(e.d));
      end
    end
  end

  task automatic push_acc(input int unsigned t, input logic wr, input logic [1:0] a, input logic [31:0] d);
    acc_t e;
    e.t = t; e.wr = wr; e.a = a; e.d = d;
    exp_bus.push_back(e);
  endtask

  // RD_ADDR at t, RD_SAMPLE at t+1, CLEAR write at t+2 when an edge is captured.
  task automatic exp_poll(input int unsigned t, input logic hit);
    push_acc(t, 1'b0, 2'd3, 32'd0);
    push_acc(t + 1, 1'b0, 2'd3, 32'd0);
    if (hit) push_acc(t + 2, 1'b1, 2'd3, 32'd1);
  endtask

  task automatic wait_cyc(input int unsigned n);
    int guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_cyc", 64'(cyc), 64'(n));
  endtask

  task automatic pulse_edge();
    edge_pulse = 1'b1;
    @(negedge clk);
    edge_pulse = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [CW-1:0] c,
                         input logic [TS_W-1:0] t, input logic o);
    chk({tag, "_valid"}, 64'(evt_valid), 64'(v));
    chk({tag, "_count"}, 64'(evt_count), 64'(c));
    chk({tag, "_time"},  64'(evt_time),  64'(t));
    chk({tag, "_ovf"},   64'(overflow),  64'(o));
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_addr"}, 64'(m_address),    64'd0);
    chk({tag, "_cs"},   64'(m_chipselect), 64'd0);
    chk({tag, "_wr_n"}, 64'(m_write_n),    64'd1);
    chk({tag, "_wd"},   64'(m_writedata),  64'd0);
  endtask

  task automatic pop_chk();
    logic [TS_W-1:0] e;
    evt_ready = 1'b1;
    #1;
    chk("pop_valid", 64'(evt_valid), 64'd1);
    if (exp_evt.size() == 0) begin
      chk("pop_unexpected_valid", 64'(evt_valid), 64'd0);
    end else begin
      e = exp_evt.pop_front();
      chk("pop_time", 64'(evt_time), 64'(e));
    end
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_bus_idle("rst");
    chk_out("rst", 1'b0, '0, '0, 1'b0);

    // Init writes, then polls every POLL_DIV+2 cycles; an edge adds a CLEAR cycle.
    push_acc(1, 1'b1, 2'd2, 32'd0);
    push_acc(2, 1'b1, 2'd3, 32'd1);
    for (int k = 0; k < 16; k++) exp_poll(6 + 6 * k, 1'b0);
    exp_poll(102, 1'b1); exp_poll(109, 1'b0); exp_poll(115, 1'b1);
    exp_poll(122, 1'b0); exp_poll(128, 1'b1); exp_poll(135, 1'b0);
    exp_poll(141, 1'b1); exp_poll(148, 1'b0); exp_poll(152, 1'b0);
    exp_poll(158, 1'b0); exp_poll(164, 1'b1);
    #2 reset_n = 1'b1;

    wait_cyc(50);
    chk_out("no_edge", 1'b0, '0, '0, 1'b0);

    // Edge captured at 101; sampled in RD_SAMPLE at ts 103.
    wait_cyc(100); pulse_edge(); exp_evt.push_back(TS_W'(103));
    wait_cyc(105);
    chk_out("evt1", 1'b1, CW'(1), TS_W'(103), 1'b0);

    wait_cyc(112); pulse_edge(); exp_evt.push_back(TS_W'(116));
    wait_cyc(118);
    chk_out("evt2", 1'b1, CW'(2), TS_W'(103), 1'b0);

    // Third event finds the FIFO full and is dropped.
    wait_cyc(125); pulse_edge();
    wait_cyc(131);
    chk_out("drop", 1'b1, CW'(2), TS_W'(103), 1'b1);
    wait_cyc(132);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);

    // Push while full, with a simultaneous pop at the end of cycle 143.
    wait_cyc(138); pulse_edge(); exp_evt.push_back(TS_W'(142));
    wait_cyc(143);
    pop_chk();
    chk_out("full_pp", 1'b1, CW'(2), TS_W'(116), 1'b0);
    pop_chk();
    chk_out("pop2", 1'b1, CW'(1), TS_W'(142), 1'b0);

    // irq at timer=1 forces RD_ADDR at 152 instead of 154.
    wait_cyc(151);
    pio_irq = 1'b1;
    @(negedge clk);
    pio_irq = 1'b0;

    // Reset during the CLEAR write at 166, with one event still queued.
    wait_cyc(160); pulse_edge();
    wait_cyc(166);
    #2 reset_n = 1'b0;
    exp_evt.delete();
    @(negedge clk);
    chk_bus_idle("rst2");
    chk_out("rst2", 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    push_acc(1, 1'b1, 2'd2, 32'd0);
    push_acc(2, 1'b1, 2'd3, 32'd1);
    exp_poll(6, 1'b0);
    #2 reset_n = 1'b1;
    wait_cyc(9);
    chk("bus_drained", 64'(exp_bus.size()), 64'd0);
    chk("evt_drained", 64'(exp_evt.size()), 64'd0);
    chk_out("post_rst", 1'b0, '0, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
